// File: rtl/instr_loader.sv
// Push-button instruction loader: synchronises and debounces a raw button,
// assembles BEATS switch samples per word and queues words in a show-ahead FIFO.
module instr_loader #(
   parameter int DATA_W   = 8,
   parameter int BEATS    = 2,
   parameter int DEBOUNCE = 16,
   parameter int DEPTH    = 4
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [DATA_W-1:0]                        din,
   input  logic                                     btn,
   input  logic                                     clr,
   output logic [DATA_W*BEATS-1:0]                  instr_out,
   output logic                                     instr_valid,
   input  logic                                     instr_ready,
   output logic [((BEATS > 1) ? $clog2(BEATS) : 1)-1:0] beat_idx,
   output logic                                     busy,
   output logic [$clog2(DEPTH):0]                   fifo_count,
   output logic                                     overflow
);

   localparam int IW = DATA_W * BEATS;
   localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE - 1);
   localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

   // ---------------------------------------------------------------
   // Button synchroniser and debouncer
   // ---------------------------------------------------------------
   logic          s0;
   logic          s1;
   logic          deb;
   logic          deb_d;
   logic [CW-1:0] cnt;
   logic          press;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0    <= 1'b0;
         s1    <= 1'b0;
         deb   <= 1'b0;
         deb_d <= 1'b0;
         cnt   <= '0;
      end else begin
         s0    <= btn;
         s1    <= s0;
         deb_d <= deb;
         if (s1 == deb) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            deb <= s1;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign press = deb & ~deb_d;

   // ---------------------------------------------------------------
   // Beat assembly
   // ---------------------------------------------------------------
   logic [IW-1:0] asm_word;
   logic [IW-1:0] word;
   logic          capture;
   logic          last_beat;
   logic          push;
   logic          pop;
   logic          full;
   logic          push_ok;
   logic          drop;

   // clr has priority over a coincident press, so it also masks the capture
   assign capture   = press & ~clr;
   assign last_beat = (beat_idx == LAST_BEAT);
   assign push      = capture & last_beat;

   always_comb begin
      word = asm_word;
      for (int unsigned i = 0; i < BEATS; i++) begin
         if (beat_idx == BW'(i)) begin
            word[i*DATA_W +: DATA_W] = din;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_idx <= '0;
         asm_word <= '0;
         overflow <= 1'b0;
      end else begin
         if (clr) begin
            beat_idx <= '0;
            asm_word <= '0;
            overflow <= 1'b0;
         end else if (capture) begin
            if (last_beat) begin
               beat_idx <= '0;
               asm_word <= '0;
            end else begin
               beat_idx <= beat_idx + 1'b1;
               asm_word <= word;
            end
            if (drop) begin
               overflow <= 1'b1;
            end
         end
      end
   end

   assign busy = (beat_idx != '0);

   // ---------------------------------------------------------------
   // Show-ahead FIFO
   // ---------------------------------------------------------------
   logic [IW-1:0] mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;

   assign instr_valid = (fifo_count != '0);
   assign full        = (fifo_count == FULL_CNT);
   assign pop         = instr_valid & instr_ready;
   // A full FIFO still accepts a word when the head leaves on the same edge
   assign push_ok     = push & (~full | pop);
   assign drop        = push & full & ~pop;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wp] <= word;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp         <= '0;
         rp         <= '0;
         fifo_count <= '0;
      end else begin
         if (push_ok) begin
            wp <= wp + 1'b1;
         end
         if (pop) begin
            rp <= rp + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign instr_out = instr_valid ? mem[rp] : '0;

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Parametrised successor to the single-shot DIP-switch/push-button instruction latch.
- Debounces a raw push-button, assembles BEATS consecutive DATA_W-wide switch samples into one instruction word, and buffers completed words in a show-ahead FIFO.
- Words are delivered to the CPU core over a valid/ready handshake.
- Sits between the top-level pins (ui_in, uio_in[0]) and cpu_core.

Parameters:
- DATA_W, 8: width of switch input per beat.
- BEATS, 2: beats per instruction (>=1); instruction width IW = DATA_W*BEATS.
- DEBOUNCE, 16: consecutive synchronised cycles a new button level must hold before it is accepted (>=1).
- DEPTH, 4: FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  DATA_W  switch data, sampled on an accepted press.
- btn  in  1  raw, asynchronous, bouncy push-button.
- clr  in  1  synchronous: discard partial word, clear overflow.
- instr_out  out  IW  FIFO head word; 0 when empty.
- instr_valid  out  1  FIFO non-empty.
- instr_ready  in  1  consumer accepts head this cycle.
- beat_idx  out  max(1,clog2(BEATS))  index of the next beat to capture.
- busy  out  1  beat_idx != 0 (partial word held).
- fifo_count  out  clog2(DEPTH)+1  entries held, 0..DEPTH.
- overflow  out  1  sticky: a completed word was dropped.

Behaviour:
- Reset (async assert, sync release): sync flops, debounced level, debounce counter, beat_idx, assembly register, FIFO pointers and count, and overflow all clear to 0. All outputs read 0.
- Synchroniser: two flops, s0 <= btn, s1 <= s0.
- Debounce:
  - deb holds the accepted level.
  - If s1 == deb, cnt <= 0.
  - Otherwise cnt increments. When cnt == DEBOUNCE-1, deb <= s1 and cnt <= 0.
  - A mismatch broken before DEBOUNCE cycles resets cnt; no level change results.
  - press = deb & ~deb_d, where deb_d is deb delayed by one flop. press is high for exactly one cycle per accepted rising level. Falling levels are debounced identically but produce no press.
- Latency: let E0 be the first clock edge at which btn is sampled high and held clean. deb rises at edge E0+DEBOUNCE+1, and din is captured at edge E0+DEBOUNCE+2.
- Assembly:
  - On press, din is written to beat slot beat_idx. Beat 0 occupies bits [DATA_W-1:0], so the low field is entered first.
  - beat_idx increments; it wraps to 0 after BEATS-1.
  - On the final beat, the word {din, held beats} is pushed to the FIFO on the same edge.
- Full FIFO on a final beat:
  - Without a simultaneous pop: the word is dropped, overflow <= 1, beat_idx <= 0.
  - With a simultaneous pop (instr_valid & instr_ready): the push succeeds and fifo_count is unchanged.
- clr:
  - beat_idx <= 0, the partial word is discarded, overflow <= 0.
  - FIFO contents are untouched.
  - If clr and press occur in the same cycle, clr wins and din is not captured.
- FIFO:
  - instr_valid = (fifo_count != 0).
  - Pop on instr_valid & instr_ready. The next head appears on instr_out the following cycle.
  - instr_ready while empty has no effect; count never underflows.
  - Push and pop in the same cycle on a non-full FIFO leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Mid-operation reset: the partial word and all FIFO contents are lost. A button held high through reset release is treated as a new rising level, so a press follows after DEBOUNCE+2 edges.

Test Plan (DATA_W=8, BEATS=2, DEBOUNCE=4, DEPTH=4 unless noted):
- Clean press, din=0x3A, release, press, din=0xC5 -> after the second capture edge: instr_valid=1, instr_out=0xC53A, fifo_count=1. First capture occurs exactly at edge E0+6.
- Bounce: btn toggles high/low every 2 cycles for 20 cycles, then holds low -> no press, beat_idx stays 0. The same pattern ending held high -> exactly one capture.
- Five complete words with instr_ready=0 -> fifo_count=4, overflow=1, and the 5th word is absent. Popping four times yields words 1-4 in order, then instr_valid=0 and instr_out=0.
- FIFO full and a final-beat press in the same cycle as instr_ready=1 -> fifo_count stays 4, the old head leaves, the new word is last, and overflow stays 0.
- One beat entered (busy=1, beat_idx=1), then clr pulsed in the same cycle as a press -> beat_idx=0, busy=0, overflow=0, and the next two presses form a fresh word.
- rst asserted with 2 words queued and 1 beat pending -> all outputs 0 immediately, asynchronously. With btn held high through release, the first capture occurs DEBOUNCE+2 edges after the first sampling edge.
